// File: rtl/fwft_sync_fifo.sv
// Single-clock FIFO with build-time choice between registered-read and first-word-fall-through.
// Occupancy count includes the FWFT output register; overflow/underflow pulse for one cycle per rejected request.
module fwft_sync_fifo #(
    parameter int DWIDTH      = 32,
    parameter int DEPTH       = 16,
    parameter int AMOST_FULL  = 4,
    parameter int AMOST_EMPTY = 4,
    parameter int FWFT        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH-1:0]        din,
    input  logic                     write,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     read,
    output logic [DWIDTH-1:0]        dout,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     ramCount;
    logic              prefetched_q, prefetched_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              overflow_q, underflow_q;
    logic              wrEn, rdEn, fetch, emptyInt;

    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(DEPTH - AMOST_FULL));
    assign almost_empty = (count_q <= CW'(AMOST_EMPTY));
    assign emptyInt     = (FWFT != 0) ? !prefetched_q : (count_q == '0);
    assign empty        = emptyInt;
    assign count        = count_q;
    assign dout         = dout_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // In FWFT mode the RAM holds count minus the word parked in the output register.
    always_comb begin
        wrEn         = write && !full;
        rdEn         = read && !emptyInt;
        ramCount     = count_q - {{AW{1'b0}}, prefetched_q};
        prefetched_d = prefetched_q;
        if (FWFT != 0) begin
            fetch = (ramCount != '0) && (!prefetched_q || rdEn);
            if (fetch) begin
                prefetched_d = 1'b1;
            end else if (rdEn) begin
                prefetched_d = 1'b0;
            end
        end else begin
            fetch = rdEn;
        end
        wrPtr_d = wrEn  ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = fetch ? rdPtr_q + AW'(1) : rdPtr_q;
        dout_d  = fetch ? mem_q[rdPtr_q] : dout_q;
        count_d = count_q;
        case ({wrEn, rdEn})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            prefetched_q <= 1'b0;
            dout_q       <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            prefetched_q <= prefetched_d;
            dout_q       <= dout_d;
            overflow_q   <= write && full;
            underflow_q  <= read && emptyInt;
        end
    end

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Directed bench driving a standard-read and an FWFT instance with the same inputs,
// comparing both against hand-computed values and small per-mode reference models.
module tb_fwft_sync_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;

    logic        sFull, sAfull, sEmpty, sAempty, sOvf, sUnf;
    logic [31:0] sDout;
    logic [4:0]  sCount;
    logic        fFull, fAfull, fEmpty, fAempty, fOvf, fUnf;
    logic [31:0] fDout;
    logic [4:0]  fCount;

    int assertCount = 0;
    int failCount   = 0;

    fwft_sync_fifo #(.DWIDTH(32), .DEPTH(16), .AMOST_FULL(4), .AMOST_EMPTY(4), .FWFT(0)) uStd (
        .clk(clk), .rst(rst), .din(din), .write(write), .full(sFull), .almost_full(sAfull),
        .read(read), .dout(sDout), .empty(sEmpty), .almost_empty(sAempty), .count(sCount),
        .overflow(sOvf), .underflow(sUnf)
    );

    fwft_sync_fifo #(.DWIDTH(32), .DEPTH(16), .AMOST_FULL(4), .AMOST_EMPTY(4), .FWFT(1)) uFwft (
        .clk(clk), .rst(rst), .din(din), .write(write), .full(fFull), .almost_full(fAfull),
        .read(read), .dout(fDout), .empty(fEmpty), .almost_empty(fAempty), .count(fCount),
        .overflow(fOvf), .underflow(fUnf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are held across exactly one rising edge, then sampled 1 time unit later.
    task automatic applyStimulus(input logic w, input logic r, input logic [31:0] d);
        write = w;
        read  = r;
        din   = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkResetState(input string who, input logic e, input logic ae, input logic f,
                                   input logic af, input logic [4:0] c, input logic [31:0] d,
                                   input logic o, input logic u);
        checkOutput({who, " empty"}, 64'(e), 64'd1);
        checkOutput({who, " almost_empty"}, 64'(ae), 64'd1);
        checkOutput({who, " full"}, 64'(f), 64'd0);
        checkOutput({who, " almost_full"}, 64'(af), 64'd0);
        checkOutput({who, " count"}, 64'(c), 64'd0);
        checkOutput({who, " dout"}, 64'(d), 64'd0);
        checkOutput({who, " overflow"}, 64'(o), 64'd0);
        checkOutput({who, " underflow"}, 64'(u), 64'd0);
    endtask

    logic [31:0] sq[$];
    logic [31:0] fq[$];
    int          sCnt, fCnt;
    logic        fPf;
    logic [31:0] sExpDout, fExpDout;

    initial begin
        // Reset then idle
        resetDut();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkResetState("std reset", sEmpty, sAempty, sFull, sAfull, sCount, sDout, sOvf, sUnf);
        checkResetState("fwft reset", fEmpty, fAempty, fFull, fAfull, fCount, fDout, fOvf, fUnf);

        // FWFT two-cycle write-to-visible latency
        applyStimulus(1'b1, 1'b0, 32'hA5);
        checkOutput("fwft empty after write", 64'(fEmpty), 64'd1);
        checkOutput("fwft count after write", 64'(fCount), 64'd1);
        checkOutput("std empty after write", 64'(sEmpty), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("fwft empty visible", 64'(fEmpty), 64'd0);
        checkOutput("fwft dout visible", 64'(fDout), 64'hA5);
        applyStimulus(1'b0, 1'b1, 32'h0);
        checkOutput("fwft empty after read", 64'(fEmpty), 64'd1);
        checkOutput("fwft count after read", 64'(fCount), 64'd0);
        checkOutput("fwft dout held", 64'(fDout), 64'hA5);
        checkOutput("std dout after read", 64'(sDout), 64'hA5);
        checkOutput("std empty after read", 64'(sEmpty), 64'd1);

        // Fill to full, overflow, then drain in order
        resetDut();
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b0, 32'(k));
            checkOutput($sformatf("fill count %0d", k), 64'(sCount), 64'(k));
            checkOutput($sformatf("fill afull %0d", k), 64'(sAfull), 64'(k >= 12));
            checkOutput($sformatf("fill full %0d", k), 64'(sFull), 64'(k == 16));
            checkOutput($sformatf("fwft fill count %0d", k), 64'(fCount), 64'(k));
        end
        applyStimulus(1'b1, 1'b0, 32'd17);
        checkOutput("std overflow pulse", 64'(sOvf), 64'd1);
        checkOutput("std count after overflow", 64'(sCount), 64'd16);
        checkOutput("fwft overflow pulse", 64'(fOvf), 64'd1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("std overflow cleared", 64'(sOvf), 64'd0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h0);
            checkOutput($sformatf("drain dout %0d", k), 64'(sDout), 64'(k));
            checkOutput($sformatf("drain count %0d", k), 64'(sCount), 64'(16 - k));
            checkOutput($sformatf("drain aempty %0d", k), 64'(sAempty), 64'((16 - k) <= 4));
        end
        checkOutput("std empty after drain", 64'(sEmpty), 64'd1);
        checkOutput("fwft empty after drain", 64'(fEmpty), 64'd1);

        // Randomised wrap-around against per-mode reference models
        resetDut();
        sq.delete(); fq.delete();
        sCnt = 0; fCnt = 0; fPf = 1'b0; sExpDout = '0; fExpDout = '0;
        for (int i = 0; i < 64; i++) begin
            logic w, r, sWr, sRd, fWr, fRd, fFetch;
            logic [31:0] d;
            w = (i < 28) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            r = (i < 28) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
            d = $urandom;
            sWr = w && (sCnt < 16);
            sRd = r && (sCnt > 0);
            fWr = w && (fCnt < 16);
            fRd = r && fPf;
            fFetch = (fq.size() > 0) && (!fPf || fRd);
            if (sRd) sExpDout = sq.pop_front();
            if (sWr) sq.push_back(d);
            sCnt = sCnt + int'(sWr) - int'(sRd);
            if (fFetch) begin
                fExpDout = fq.pop_front();
                fPf = 1'b1;
            end else if (fRd) begin
                fPf = 1'b0;
            end
            if (fWr) fq.push_back(d);
            fCnt = fCnt + int'(fWr) - int'(fRd);
            applyStimulus(w, r, d);
            checkOutput($sformatf("wrap std count %0d", i), 64'(sCount), 64'(sCnt));
            checkOutput($sformatf("wrap std dout %0d", i), 64'(sDout), 64'(sExpDout));
            checkOutput($sformatf("wrap std ovf %0d", i), 64'(sOvf), 64'(w && !sWr));
            checkOutput($sformatf("wrap std unf %0d", i), 64'(sUnf), 64'(r && !sRd));
            checkOutput($sformatf("wrap fwft count %0d", i), 64'(fCount), 64'(fCnt));
            checkOutput($sformatf("wrap fwft empty %0d", i), 64'(fEmpty), 64'(!fPf));
            checkOutput($sformatf("wrap fwft dout %0d", i), 64'(fDout), 64'(fExpDout));
            checkOutput($sformatf("wrap fwft unf %0d", i), 64'(fUnf), 64'(r && !fRd));
        end

        // Simultaneous read+write when full
        resetDut();
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, 32'h100 + 32'(k));
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("fwft head before rw", 64'(fDout), 64'h100);
        applyStimulus(1'b1, 1'b1, 32'hDEAD);
        checkOutput("full rw std dout", 64'(sDout), 64'h100);
        checkOutput("full rw std count", 64'(sCount), 64'd15);
        checkOutput("full rw std ovf", 64'(sOvf), 64'd1);
        checkOutput("full rw fwft dout", 64'(fDout), 64'h101);
        checkOutput("full rw fwft count", 64'(fCount), 64'd15);
        checkOutput("full rw fwft ovf", 64'(fOvf), 64'd1);

        // Simultaneous read+write when empty
        resetDut();
        applyStimulus(1'b1, 1'b1, 32'h77);
        checkOutput("empty rw std unf", 64'(sUnf), 64'd1);
        checkOutput("empty rw std count", 64'(sCount), 64'd1);
        checkOutput("empty rw fwft unf", 64'(fUnf), 64'd1);
        checkOutput("empty rw fwft count", 64'(fCount), 64'd1);
        checkOutput("empty rw std dout", 64'(sDout), 64'd0);

        // Mid-cycle asynchronous reset with nine words held
        resetDut();
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0, 32'h200 + 32'(k));
        applyStimulus(1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h209);
        checkOutput("pre-reset std count", 64'(sCount), 64'd9);
        #3;
        rst = 1'b1;
        #1;
        checkResetState("async std", sEmpty, sAempty, sFull, sAfull, sCount, sDout, sOvf, sUnf);
        checkResetState("async fwft", fEmpty, fAempty, fFull, fAfull, fCount, fDout, fOvf, fUnf);
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h3C);
        checkOutput("rt std count", 64'(sCount), 64'd1);
        checkOutput("rt fwft empty", 64'(fEmpty), 64'd1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rt fwft dout", 64'(fDout), 64'h3C);
        checkOutput("rt fwft visible", 64'(fEmpty), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'h0);
        checkOutput("rt std dout", 64'(sDout), 64'h3C);
        checkOutput("rt std empty", 64'(sEmpty), 64'd1);
        checkOutput("rt fwft empty after read", 64'(fEmpty), 64'd1);
        checkOutput("rt fwft count", 64'(fCount), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
